// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA modular exponentiation core: state
// encoding, default operand widths and a latency helper.
package rsa_pkg;

    localparam int RSA_WIDTH     = 128;
    localparam int RSA_EXP_WIDTH = 128;

    // NEXT is kept in the encoding for state-map readability; its work
    // (index increment and branch) is folded into the last SQR cycle.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        MUL  = 3'd2,
        SQR  = 3'd3,
        NEXT = 3'd4,
        DONE = 3'd5
    } rsa_state_t;

    // Cycles from the start edge to the cycle in which done is high.
    function automatic int unsigned rsa_latency(
        input int unsigned width,
        input int unsigned exp_width,
        input int unsigned popcount,
        input bit          const_time,
        input bit          op_err
    );
        if (op_err)
            return 2;
        else if (const_time)
            return 2 + 2 * exp_width * width;
        else
            return 2 + width * (exp_width + popcount);
    endfunction

endpackage

// File: rtl/modmul_serial.sv
// Interleaved MSB-first shift-add modular multiplier: p = a*b mod n.
// Operands must be held stable for WIDTH cycles starting with the cycle
// in which start is high; done is high in the WIDTH-th cycle, with p
// valid in that same cycle. Requires a < 2^WIDTH, b < n.
module modmul_serial
    import rsa_pkg::*;
#(
    parameter int WIDTH = RSA_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] n,
    output logic             done,
    output logic [WIDTH-1:0] p
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int AW = WIDTH + 2;

    logic [WIDTH-1:0] r_acc;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] w_acc_in;
    logic [CW-1:0]    w_cnt;
    logic [AW-1:0]    w_n_ext;
    logic [AW-1:0]    w_sum;
    logic [AW-1:0]    w_sub1;

    // One shift-add step with two conditional subtractions; the first
    // cycle of a multiply starts from a zero accumulator at the top bit.
    always_comb begin
        w_acc_in = start ? '0 : r_acc;
        w_cnt    = start ? CW'(WIDTH - 1) : r_cnt;
        w_n_ext  = {2'b00, n};
        w_sum    = {1'b0, w_acc_in, 1'b0} + (a[w_cnt] ? {2'b00, b} : '0);
        w_sub1   = (w_sum >= w_n_ext) ? (w_sum - w_n_ext) : w_sum;
        // The second reduced value is < n, so WIDTH bits suffice.
        p        = (w_sub1 >= w_n_ext) ? (w_sub1[WIDTH-1:0] - n) : w_sub1[WIDTH-1:0];
        done     = (w_cnt == '0);
    end

    // Accumulator and bit counter advance every cycle; start re-seeds them.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else begin
            r_acc <= p;
            r_cnt <= w_cnt - 1'b1;
        end
    end

endmodule

// File: rtl/rsa_modexp_core.sv
// RSA modular exponentiation c = m^e mod n, right-to-left square-and-
// multiply over all exponent bits, sharing one serial modular multiplier.
// Optional macro RSA_CONST_TIME_EN: run MUL for every exponent bit and
// discard the product for 0 bits, making latency independent of e_key.
// Handshake: start is accepted only while busy is low; done pulses for one
// cycle with c and err valid; c then holds until the next completion.
module rsa_modexp_core
    import rsa_pkg::*;
#(
    parameter int WIDTH     = RSA_WIDTH,
    parameter int EXP_WIDTH = RSA_EXP_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     message,
    input  logic [EXP_WIDTH-1:0] e_key,
    input  logic [WIDTH-1:0]     n,
    output logic [WIDTH-1:0]     c,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [2:0]           dbg_state
);

    localparam int IDX_W = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;

    rsa_state_t           r_state;
    rsa_state_t           w_state_nxt;
    logic                 r_mm_start;
    logic                 w_mm_start_nxt;
    logic [WIDTH-1:0]     r_result;
    logic [WIDTH-1:0]     r_base;
    logic [WIDTH-1:0]     r_n;
    logic [WIDTH-1:0]     r_c;
    logic [EXP_WIDTH-1:0] r_e;
    logic [IDX_W-1:0]     r_idx;
    logic                 r_done;
    logic                 r_err;
    logic [IDX_W-1:0]     w_idx_inc;
    logic                 w_load_err;
    logic                 w_last_bit;
    logic                 w_cur_bit;
    logic                 w_mul_first;
    logic                 w_mul_next;
    logic                 w_mm_done;
    logic [WIDTH-1:0]     w_mm_a;
    logic [WIDTH-1:0]     w_mm_p;

    assign w_idx_inc  = r_idx + 1'b1;
    assign w_load_err = (r_n < WIDTH'(2)) || (r_base >= r_n);
    assign w_last_bit = (r_idx == IDX_W'(EXP_WIDTH - 1));
    assign w_cur_bit  = r_e[r_idx];
    assign w_mm_a     = (r_state == MUL) ? r_result : r_base;

`ifdef RSA_CONST_TIME_EN
    assign w_mul_first = 1'b1;
    assign w_mul_next  = 1'b1;
`else
    assign w_mul_first = r_e[0];
    assign w_mul_next  = r_e[w_idx_inc];
`endif

    modmul_serial #(.WIDTH(WIDTH)) u_modmul (
        .clk   (clk),
        .reset (reset),
        .start (r_mm_start),
        .a     (w_mm_a),
        .b     (r_base),
        .n     (r_n),
        .done  (w_mm_done),
        .p     (w_mm_p)
    );

    // State register plus the multiplier start strobe for the next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_mm_start <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_mm_start <= w_mm_start_nxt;
        end
    end

    // Next-state logic; every entry into MUL or SQR launches a multiply.
    always_comb begin
        w_state_nxt    = r_state;
        w_mm_start_nxt = 1'b0;
        case (r_state)
            IDLE: if (start) w_state_nxt = LOAD;
            LOAD: begin
                if (w_load_err) begin
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt    = w_mul_first ? MUL : SQR;
                    w_mm_start_nxt = 1'b1;
                end
            end
            MUL: begin
                if (w_mm_done) begin
                    w_state_nxt    = SQR;
                    w_mm_start_nxt = 1'b1;
                end
            end
            SQR: begin
                if (w_mm_done) begin
                    if (w_last_bit) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt    = w_mul_next ? MUL : SQR;
                        w_mm_start_nxt = 1'b1;
                    end
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Datapath: operand capture, result/base updates and completion outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_result <= '0;
            r_base   <= '0;
            r_n      <= '0;
            r_e      <= '0;
            r_idx    <= '0;
            r_c      <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_base <= message;
                        r_e    <= e_key;
                        r_n    <= n;
                    end
                end
                LOAD: begin
                    if (w_load_err) begin
                        r_done <= 1'b1;
                        r_err  <= 1'b1;
                        r_c    <= '0;
                    end else begin
                        r_result <= WIDTH'(1);
                        r_idx    <= '0;
                    end
                end
                MUL: begin
                    if (w_mm_done && w_cur_bit) r_result <= w_mm_p;
                end
                SQR: begin
                    if (w_mm_done) begin
                        r_base <= w_mm_p;
                        r_idx  <= w_idx_inc;
                        if (w_last_bit) begin
                            r_done <= 1'b1;
                            r_c    <= r_result;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (r_state != IDLE);
    assign done      = r_done;
    assign err       = r_err;
    assign c         = r_c;
    assign dbg_state = r_state;

endmodule
